// File: rtl/ahb_pkg.sv
// Shared AHB encodings, widths, slave FSM states and the byte-lane strobe helper.
package ahb_pkg;

   localparam int unsigned AHB_ADDR_BITS  = 32;
   localparam int unsigned AHB_TRANS_BITS = 2;
   localparam int unsigned AHB_SIZE_BITS  = 3;
   localparam int unsigned AHB_DATA_BITS  = 32;
   localparam int unsigned AHB_RESP_BITS  = 1;
   localparam int unsigned AHB_LANES      = AHB_DATA_BITS / 8;

   localparam logic [AHB_TRANS_BITS-1:0] HTRANS_IDLE   = 2'd0;
   localparam logic [AHB_TRANS_BITS-1:0] HTRANS_BUSY   = 2'd1;
   localparam logic [AHB_TRANS_BITS-1:0] HTRANS_NONSEQ = 2'd2;
   localparam logic [AHB_TRANS_BITS-1:0] HTRANS_SEQ    = 2'd3;

   localparam logic [AHB_RESP_BITS-1:0] HRESP_OKAY  = 1'b0;
   localparam logic [AHB_RESP_BITS-1:0] HRESP_ERROR = 1'b1;

   localparam logic [AHB_SIZE_BITS-1:0] HSIZE_BYTE = 3'd0;
   localparam logic [AHB_SIZE_BITS-1:0] HSIZE_HALF = 3'd1;
   localparam logic [AHB_SIZE_BITS-1:0] HSIZE_WORD = 3'd2;

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_t;

   // Little-endian lane strobe for a (legal) size and low address bits.
   function automatic logic [AHB_LANES-1:0] lane_enable(input logic [AHB_SIZE_BITS-1:0] size,
                                                        input logic [1:0] lane);
      logic [AHB_LANES-1:0] be;
      be = '0;
      case (size)
         HSIZE_BYTE: be = 4'b0001 << lane;
         HSIZE_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
         HSIZE_WORD: be = 4'b1111;
         default:    be = 4'b0000;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// AHB slave-side signal bundle.
//   slave modport : HSEL/HADDR/HTRANS/HWRITE/HSIZE/HWDATA/HREADY in,
//                   HREADYOUT/HRESP/HRDATA out.
//   master modport: the mirror image (HREADY observed as an input).
interface ahb_sram_slave_if;
   import ahb_pkg::*;

   logic                      HSEL;
   logic [AHB_ADDR_BITS-1:0]  HADDR;
   logic [AHB_TRANS_BITS-1:0] HTRANS;
   logic                      HWRITE;
   logic [AHB_SIZE_BITS-1:0]  HSIZE;
   logic [AHB_DATA_BITS-1:0]  HWDATA;
   logic                      HREADY;
   logic                      HREADYOUT;
   logic [AHB_RESP_BITS-1:0]  HRESP;
   logic [AHB_DATA_BITS-1:0]  HRDATA;

   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
      output HREADYOUT, HRESP, HRDATA
   );

   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
      input  HREADY, HREADYOUT, HRESP, HRDATA
   );
endinterface

// File: rtl/ahb_sram_array.sv
// Byte-enabled single-port word memory: synchronous write, asynchronous read.
//   HCLK  : clock
//   we/be : write enable and per-lane strobes
//   waddr/wdata : write word index and data
//   raddr/rdata : read word index and combinational read data
// Contents are deliberately not reset.
module ahb_sram_array
   import ahb_pkg::*;
#(
   parameter  int unsigned MEM_WORDS = 1024,
   localparam int unsigned IDX_BITS  = $clog2(MEM_WORDS)
) (
   input  logic                     HCLK,
   input  logic                     we,
   input  logic [AHB_LANES-1:0]     be,
   input  logic [IDX_BITS-1:0]      waddr,
   input  logic [AHB_DATA_BITS-1:0] wdata,
   input  logic [IDX_BITS-1:0]      raddr,
   output logic [AHB_DATA_BITS-1:0] rdata
);

   logic [AHB_DATA_BITS-1:0] mem [MEM_WORDS];

   // Only enabled lanes are updated.
   always_ff @(posedge HCLK) begin
      if (we) begin
         for (int i = 0; i < int'(AHB_LANES); i++) begin
            if (be[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
         end
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB SRAM slave: accepts pipelined transfers, inserts WAIT_STATES stall
// cycles per OKAY transfer, answers illegal transfers with a two-cycle ERROR.
//   HCLK   : bus clock
//   HRESET : asynchronous active-high reset
//   bus    : slave modport (address/control/write data in; ready/resp/read data out)
module ahb_sram_slave
   import ahb_pkg::*;
#(
   parameter int unsigned MEM_WORDS   = 1024,
   parameter int unsigned WAIT_STATES = 0
) (
   input logic             HCLK,
   input logic             HRESET,
   ahb_sram_slave_if.slave bus
);

   localparam int unsigned IDX_BITS  = $clog2(MEM_WORDS);
   localparam int unsigned CNT_BITS  = 3;
   localparam int unsigned WIDX_BITS = AHB_ADDR_BITS - 2;

   state_t                   state;
   logic [CNT_BITS-1:0]      cnt;
   logic [IDX_BITS-1:0]      idx_q;
   logic [1:0]               lane_q;
   logic [AHB_SIZE_BITS-1:0] size_q;
   logic                     write_q;
   logic                     ready_q;
   logic [AHB_RESP_BITS-1:0] resp_q;

   logic                     accept_c;
   logic                     legal_c;
   logic                     data_done_c;
   logic                     we_c;
   logic [AHB_LANES-1:0]     be_c;
   logic [AHB_DATA_BITS-1:0] rdata_c;

   assign data_done_c = (state == S_DATA) && (cnt == '0);
   assign accept_c    = bus.HSEL && bus.HREADY &&
                        ((bus.HTRANS == HTRANS_NONSEQ) || (bus.HTRANS == HTRANS_SEQ));

   // Range, size and alignment legality of the address phase on the bus.
   always_comb begin
      legal_c = 1'b1;
      if (bus.HADDR[AHB_ADDR_BITS-1:2] >= WIDX_BITS'(MEM_WORDS)) legal_c = 1'b0;
      if (bus.HSIZE > HSIZE_WORD) legal_c = 1'b0;
      if ((bus.HSIZE == HSIZE_HALF) && bus.HADDR[0]) legal_c = 1'b0;
      if ((bus.HSIZE == HSIZE_WORD) && (bus.HADDR[1:0] != 2'b00)) legal_c = 1'b0;
   end

   // Transfer FSM; ready/resp are registered alongside the state they describe.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state   <= S_IDLE;
         cnt     <= '0;
         idx_q   <= '0;
         lane_q  <= '0;
         size_q  <= '0;
         write_q <= 1'b0;
         ready_q <= 1'b1;
         resp_q  <= HRESP_OKAY;
      end else if (state == S_ERR1) begin
         state   <= S_ERR2;
         ready_q <= 1'b1;
         resp_q  <= HRESP_ERROR;
      end else if ((state == S_DATA) && (cnt != '0)) begin
         cnt     <= cnt - 1'b1;
         ready_q <= (cnt == CNT_BITS'(1));
      end else if (accept_c) begin
         idx_q   <= bus.HADDR[IDX_BITS+1:2];
         lane_q  <= bus.HADDR[1:0];
         size_q  <= bus.HSIZE;
         write_q <= bus.HWRITE;
         if (legal_c) begin
            state   <= S_DATA;
            cnt     <= CNT_BITS'(WAIT_STATES);
            ready_q <= (WAIT_STATES == 0);
            resp_q  <= HRESP_OKAY;
         end else begin
            state   <= S_ERR1;
            ready_q <= 1'b0;
            resp_q  <= HRESP_ERROR;
         end
      end else begin
         state   <= S_IDLE;
         ready_q <= 1'b1;
         resp_q  <= HRESP_OKAY;
      end
   end

   // Write commits on the edge closing the final data cycle.
   assign we_c = data_done_c && write_q;
   assign be_c = lane_enable(size_q, lane_q);

   ahb_sram_array #(.MEM_WORDS(MEM_WORDS)) u_array (
      .HCLK  (HCLK),
      .we    (we_c),
      .be    (be_c),
      .waddr (idx_q),
      .wdata (bus.HWDATA),
      .raddr (idx_q),
      .rdata (rdata_c)
   );

   assign bus.HREADYOUT = ready_q;
   assign bus.HRESP     = resp_q;
   assign bus.HRDATA    = ((state == S_DATA) && !write_q) ? rdata_c : '0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench: three slaves (0, 2 and 3 wait states) share one stimulus stream, only
// the selected one sees HSEL. A byte-addressed reference memory produces the
// expected response of each transfer; a negedge monitor pops and compares.
module tb_ahb_sram_slave;
   import ahb_pkg::*;

   localparam int unsigned MW = 64;

   typedef struct {
      bit          err;
      bit          rd;
      logic [31:0] rdata;
   } sb_t;

   logic        clk;
   logic        m_rst;
   logic        m_hsel;
   logic [31:0] m_haddr;
   logic [1:0]  m_htrans;
   logic        m_hwrite;
   logic [2:0]  m_hsize;
   logic [31:0] m_hwdata;
   logic [1:0]  cur;
   bit          done;

   logic        rdy  [3];
   logic        resp [3];
   logic [31:0] dat  [3];

   logic [7:0]  mdl [3][MW*4];
   sb_t         sb [$];

   int          n_chk;
   int          n_fail;
   bit          ph_active;
   int          ph_k;
   sb_t         ph;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   for (genvar g = 0; g < 3; g++) begin : gen_dut
      ahb_sram_slave_if bus ();
      assign bus.HSEL   = m_hsel && (cur == 2'(g));
      assign bus.HADDR  = m_haddr;
      assign bus.HTRANS = m_htrans;
      assign bus.HWRITE = m_hwrite;
      assign bus.HSIZE  = m_hsize;
      assign bus.HWDATA = m_hwdata;
      assign bus.HREADY = bus.HREADYOUT;
      assign rdy[g]  = bus.HREADYOUT;
      assign resp[g] = bus.HRESP;
      assign dat[g]  = bus.HRDATA;

      ahb_sram_slave #(.MEM_WORDS(MW), .WAIT_STATES((g == 0) ? 0 : g + 1)) dut (
         .HCLK   (clk),
         .HRESET (m_rst),
         .bus    (bus)
      );
   end

   function automatic int ws_of(input int g);
      return (g == 0) ? 0 : g + 1;
   endfunction

   // Reference legality: in range, size at most a word, naturally aligned.
   function automatic bit legal(input logic [31:0] a, input logic [2:0] sz);
      if (sz > 3'd2) return 1'b0;
      if ((a >> 2) >= MW) return 1'b0;
      return (a & ((32'd1 << sz) - 32'd1)) == 32'd0;
   endfunction

   function automatic void model_write(input int g, input logic [31:0] a,
                                       input logic [2:0] sz, input logic [31:0] wd);
      for (int b = 0; b < (1 << sz); b++) begin
         int ba;
         ba = int'(a) + b;
         mdl[g][ba] = 8'(wd >> (8 * (ba % 4)));
      end
   endfunction

   function automatic logic [31:0] model_read(input int g, input logic [31:0] a);
      int w;
      w = int'(a >> 2) * 4;
      return {mdl[g][w+3], mdl[g][w+2], mdl[g][w+1], mdl[g][w]};
   endfunction

   // Present one transfer, record its expectation, hold it until accepted.
   task automatic issue(input logic [31:0] a, input logic wr, input logic [2:0] sz,
                        input logic [31:0] wd, input bit seq, input bit abort);
      sb_t e;
      bit  acc;
      int  waitc;
      m_haddr  = a;
      m_hwrite = wr;
      m_hsize  = sz;
      m_htrans = seq ? HTRANS_SEQ : HTRANS_NONSEQ;
      m_hsel   = 1'b1;
      e.err    = !legal(a, sz);
      e.rd     = !wr;
      e.rdata  = '0;
      if (!e.err) begin
         if (wr) begin
            if (!abort) model_write(int'(cur), a, sz, wd);
         end else begin
            e.rdata = model_read(int'(cur), a);
         end
      end
      sb.push_back(e);
      acc   = 1'b0;
      waitc = 0;
      while (!acc) begin
         @(negedge clk);
         acc = rdy[cur];
         @(posedge clk);
         #1;
         waitc++;
         if (!acc && waitc > 20) begin
            $display("FAIL accept_timeout dut%0d addr=%h: ready still 0, required 1", cur, a);
            $fatal(1, "accept timeout");
         end
      end
      m_hwdata = wr ? wd : $urandom;
   endtask

   task automatic idle(input int n, input bit busy);
      m_htrans = busy ? HTRANS_BUSY : HTRANS_IDLE;
      m_hsel   = 1'($urandom_range(0, 1));
      m_haddr  = $urandom;
      m_hwrite = 1'($urandom_range(0, 1));
      m_hsize  = 3'($urandom_range(0, 3));
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic rand_xfer();
      logic [31:0] a;
      logic [2:0]  sz;
      int          r;
      r  = $urandom_range(0, 9);
      sz = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 9) ? 3'd2 : 3'd3;
      a  = 32'($urandom_range(0, MW * 4 + 15));
      if (sz <= 3'd2 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      issue(a, 1'($urandom_range(0, 1)), sz, $urandom, 1'($urandom_range(0, 1)), 1'b0);
   endtask

   // Stimulus
   initial begin
      m_rst = 1'b1; m_hsel = 1'b0; m_haddr = '0; m_htrans = HTRANS_IDLE;
      m_hwrite = 1'b0; m_hsize = '0; m_hwdata = '0; cur = 2'd0; done = 1'b0;
      repeat (3) @(posedge clk);
      #1 m_rst = 1'b0;
      idle(3, 1'b0);
      for (int g = 0; g < 3; g++) begin
         cur = 2'(g);
         idle(2, 1'b0);
         for (int i = 0; i < int'(MW); i++) issue(32'(i * 4), 1'b1, 3'd2, $urandom, 1'b0, 1'b0);
         idle(ws_of(g) + 2, 1'b0);
         if (g == 0) begin
            issue(32'h10, 1'b1, 3'd2, 32'hDEADBEEF, 1'b0, 1'b0);
            issue(32'h10, 1'b0, 3'd2, '0, 1'b0, 1'b0);
            idle(1, 1'b0);
            issue(32'h20, 1'b1, 3'd2, 32'h0, 1'b0, 1'b0);
            issue(32'h21, 1'b1, 3'd0, 32'hAAAAAAAA, 1'b1, 1'b0);
            issue(32'h22, 1'b1, 3'd1, {16'h5555, 16'($urandom)}, 1'b1, 1'b0);
            issue(32'h20, 1'b0, 3'd2, '0, 1'b0, 1'b0);
            idle(1, 1'b0);
            issue(32'h13, 1'b0, 3'd2, '0, 1'b0, 1'b0);
            issue(32'h13, 1'b1, 3'd2, 32'hFFFFFFFF, 1'b0, 1'b0);
            issue(32'h10, 1'b0, 3'd2, '0, 1'b0, 1'b0);
            issue(32'(MW * 4), 1'b1, 3'd2, 32'h0BAD0BAD, 1'b0, 1'b0);
            issue(32'(MW * 4 - 4), 1'b1, 3'd2, 32'hCAFEF00D, 1'b0, 1'b0);
            issue(32'(MW * 4 - 4), 1'b0, 3'd2, '0, 1'b0, 1'b0);
            issue(32'h20, 1'b1, 3'd3, 32'h11111111, 1'b0, 1'b0);
            issue(32'h20, 1'b0, 3'd3, '0, 1'b0, 1'b0);
            issue(32'h20, 1'b0, 3'd2, '0, 1'b0, 1'b0);
            idle(2, 1'b0);
         end else if (g == 1) begin
            issue(32'h10, 1'b0, 3'd2, '0, 1'b0, 1'b0);
            idle(4, 1'b0);
            issue(32'h14, 1'b0, 3'd2, '0, 1'b0, 1'b0);
            issue(32'h18, 1'b0, 3'd2, '0, 1'b0, 1'b0);
            idle(4, 1'b0);
         end else begin
            issue(32'h40, 1'b1, 3'd2, 32'h12345678, 1'b0, 1'b1);
            m_htrans = HTRANS_IDLE;
            m_hsel   = 1'b0;
            @(posedge clk);
            #1 m_rst = 1'b1;
            @(posedge clk);
            #1 m_rst = 1'b0;
            idle(2, 1'b0);
            issue(32'h40, 1'b0, 3'd2, '0, 1'b0, 1'b0);
            idle(5, 1'b0);
         end
         for (int n = 0; n < 80; n++) begin
            int gap;
            gap = $urandom_range(0, 3);
            if (gap > 0) idle(gap, 1'($urandom_range(0, 1)));
            rand_xfer();
         end
         idle(ws_of(g) + 3, 1'b0);
      end
      done = 1'b1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, required completion");
      $fatal(1, "watchdog");
   end

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d t=%0t: got %h required %h", nm, cur, $time, act, exp);
      end
   endfunction

   // Monitor: checks each cycle of the current slave's response.
   initial begin
      n_chk = 0; n_fail = 0; ph_active = 1'b0; ph_k = 0;
      forever begin
         @(negedge clk);
         if (m_rst) begin
            chk("rst_ready", 32'(rdy[cur]), 32'd1);
            chk("rst_resp", 32'(resp[cur]), 32'd0);
            chk("rst_rdata", dat[cur], 32'd0);
            ph_active = 1'b0;
         end else begin
            if (ph_active) begin
               ph_k++;
               if (ph.err) begin
                  chk("err_ready", 32'(rdy[cur]), 32'(ph_k == 2));
                  chk("err_resp", 32'(resp[cur]), 32'd1);
                  chk("err_rdata", dat[cur], 32'd0);
                  if (ph_k >= 2) ph_active = 1'b0;
               end else begin
                  chk("okay_ready", 32'(rdy[cur]), 32'(ph_k == ws_of(int'(cur)) + 1));
                  chk("okay_resp", 32'(resp[cur]), 32'd0);
                  chk(ph.rd ? "read_data" : "write_rdata", dat[cur], ph.rd ? ph.rdata : 32'd0);
                  if (ph_k >= ws_of(int'(cur)) + 1) ph_active = 1'b0;
               end
            end else begin
               chk("idle_ready", 32'(rdy[cur]), 32'd1);
               chk("idle_resp", 32'(resp[cur]), 32'd0);
               chk("idle_rdata", dat[cur], 32'd0);
            end
            if (m_hsel && rdy[cur] && m_htrans[1]) begin
               if (sb.size() == 0) begin
                  chk("unexpected_accept", 32'd1, 32'd0);
               end else begin
                  ph        = sb.pop_front();
                  ph_active = 1'b1;
                  ph_k      = 0;
               end
            end
            if (done && !ph_active) begin
               chk("sb_empty", 32'(sb.size()), 32'd0);
               $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
               $finish;
            end
         end
      end
   end

endmodule
